// File: rtl/perf_counter_bank_if.sv
// Control/read bundle for perf_counter_bank.
// Bench/CSR side is master: drives en/clr/snap/evt/rd_*; bank returns rd_data/rd_ovf/timeout.
interface perf_counter_bank_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_EVT = 4
) ();
  localparam int ADDR_W = $clog2(NUM_EVT + 1);

  logic               en;
  logic               clr;
  logic               snap;
  logic [NUM_EVT-1:0] evt;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_shadow;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_ovf;
  logic               timeout;

  modport master (
    output en, clr, snap, evt,
    output rd_addr, rd_shadow,
    input  rd_data, rd_ovf, timeout
  );

  modport slave (
    input  en, clr, snap, evt,
    input  rd_addr, rd_shadow,
    output rd_data, rd_ovf, timeout
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Cycle + event counter bank: sticky overflow, shadow snapshot, optional timeout.
// Ports: clk, rst_n (async low), bus (slave) carrying controls, events and the registered read port.
module perf_counter_bank #(
  parameter int WIDTH             = 32,
  parameter int NUM_EVT           = 4,
  parameter int TIMEOUT           = 0,
  parameter int FREEZE_ON_TIMEOUT = 1
) (
  input logic                clk,
  input logic                rst_n,
  perf_counter_bank_if.slave bus
);
  localparam int N      = NUM_EVT + 1;
  localparam int ADDR_W = $clog2(NUM_EVT + 1);

  logic [WIDTH-1:0] live_q [N];
  logic [WIDTH-1:0] shad_q [N];
  logic [N-1:0]     ovf_q;
  logic [N-1:0]     sovf_q;
  logic [N-1:0]     inc;
  logic             timeout_q;
  logic             cnt_ok;
  logic             in_range;
  logic [WIDTH-1:0] rd_nxt;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_ovf_nxt;
  logic             rd_ovf_q;

  assign cnt_ok = bus.en &
    ~(timeout_q & (FREEZE_ON_TIMEOUT != 0));

  // Slot 0 is the cycle counter, slot k+1 is event k.
  assign inc = {bus.evt, 1'b1} & {N{cnt_ok}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        live_q[i] <= '0;
      ovf_q <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < N; i++)
        live_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (inc[i]) begin
          live_q[i] <= live_q[i] + WIDTH'(1);
          if (&live_q[i])
            ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  // Shadow captures pre-edge live state, so snap+clr is read-and-reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        shad_q[i] <= '0;
      sovf_q <= '0;
    end else if (bus.snap) begin
      for (int i = 0; i < N; i++)
        shad_q[i] <= live_q[i];
      sovf_q <= ovf_q;
    end
  end

  generate
    if (TIMEOUT != 0) begin : g_to
      logic [WIDTH-1:0] cyc_nxt;
      assign cyc_nxt = live_q[0] + WIDTH'(1);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          timeout_q <= 1'b0;
        else if (bus.clr)
          timeout_q <= 1'b0;
        else if (inc[0] &&
                 cyc_nxt == WIDTH'(TIMEOUT))
          timeout_q <= 1'b1;
      end
    end else begin : g_no_to
      assign timeout_q = 1'b0;
    end
  endgenerate

  assign in_range =
    ({1'b0, bus.rd_addr} < (ADDR_W+1)'(N));

  always_comb begin
    rd_nxt     = '0;
    rd_ovf_nxt = 1'b0;
    unique case (1'b1)
      (in_range && bus.rd_shadow): begin
        rd_nxt     = shad_q[bus.rd_addr];
        rd_ovf_nxt = sovf_q[bus.rd_addr];
      end
      (in_range && !bus.rd_shadow): begin
        rd_nxt     = live_q[bus.rd_addr];
        rd_ovf_nxt = ovf_q[bus.rd_addr];
      end
      (!in_range): begin
        rd_nxt     = '0;
        rd_ovf_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_nxt;
      rd_ovf_q  <= rd_ovf_nxt;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_ovf  = rd_ovf_q;
  assign bus.timeout = timeout_q;
endmodule
